fixed_to_float_packer: RTL and testbench

Sequential packer that converts the CORDIC engine's unsigned Q0.32 magnitude plus a sign flag into an IEEE-754 single-precision word. It is the output end of the cosine datapath: the unpacker converts float to fixed on the way in, and this block converts fixed back to float on the way out. Normalisation is iterative, one bit per cycle. Rounding is round-to-nearest-even. Input and output use valid/ready handshakes.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/rne_rounder.sv | 34 +++
 rtl/fixed_to_float_packer.sv | 97 +++++++++
 tb/tb_fixed_to_float_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and types for the fixed-to-float output packer.
//   FIX_W      : width of the unsigned Q0.32 magnitude
//   FP_EXP_W   : float32 exponent width
//   FP_FRAC_W  : float32 stored fraction width
//   EXP_INIT   : biased exponent of a magnitude whose MSB is bit 31 (2^-1)
//   state_e    : packer FSM states
package fp_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FIX_W     = 32;

  // in_fixed[31]=1 means value in [0.5,1): unbiased exponent -1.
  localparam logic [FP_EXP_W-1:0] EXP_INIT = FP_EXP_W'(FP_BIAS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rne_rounder.sv
// Combinational round-to-nearest-even of a normalised Q0.32 magnitude.
// The implicit leading one (mant[31]) is dropped by the caller.
//   i_mant : mant[30:0] of the normalised magnitude
//   i_exp  : biased exponent before rounding
//   o_exp  : biased exponent after rounding (bumped on fraction carry)
//   o_frac : 23-bit rounded fraction
module rne_rounder
  import fp_pkg::*;
(
  input  logic [FIX_W-2:0]     i_mant,
  input  logic [FP_EXP_W-1:0]  i_exp,
  output logic [FP_EXP_W-1:0]  o_exp,
  output logic [FP_FRAC_W-1:0] o_frac
);

  logic [FP_FRAC_W-1:0] w_frac;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_inc;
  logic [FP_FRAC_W:0]   w_sum;

  assign w_frac   = i_mant[30:8];
  assign w_guard  = i_mant[7];
  assign w_sticky = |i_mant[6:0];

  // Exact ties round up only when the kept LSB is odd.
  assign w_inc = w_guard && (w_sticky || w_frac[0]);

  // On carry-out the low 23 bits are already zero, so only exp moves.
  assign w_sum  = {1'b0, w_frac} + (FP_FRAC_W+1)'(w_inc);
  assign o_frac = w_sum[FP_FRAC_W-1:0];
  assign o_exp  = i_exp + FP_EXP_W'(w_sum[FP_FRAC_W]);

endmodule

// File: rtl/fixed_to_float_packer.sv
// Converts an unsigned Q0.32 magnitude plus sign into an IEEE-754 single.
// Normalisation shifts one bit per cycle; rounding is round-to-nearest-even.
//   clk, reset_n         : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake (ready only in IDLE)
//   in_fixed, in_neg     : magnitude (x 2^-32) and sign
//   out_valid/out_ready  : output handshake, out_float held until accepted
//   out_float            : float32 result (zero is always +0)
module fixed_to_float_packer
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FIX_W-1:0] in_fixed,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_float
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [FIX_W-1:0]     r_mant;
  logic [FP_EXP_W-1:0]  r_exp;
  logic                 r_sign;
  logic                 r_out_valid;
  logic [31:0]          r_out_float;

  logic                 w_in_zero;
  logic [FP_EXP_W-1:0]  w_rnd_exp;
  logic [FP_FRAC_W-1:0] w_rnd_frac;

  assign w_in_zero = (in_fixed == '0);

  rne_rounder u_rnd (
    .i_mant (r_mant[FIX_W-2:0]),
    .i_exp  (r_exp),
    .o_exp  (w_rnd_exp),
    .o_frac (w_rnd_frac)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (in_valid) w_state_nxt = w_in_zero ? DONE : NORM;
      NORM:  if (r_mant[FIX_W-1]) w_state_nxt = ROUND;
      ROUND: w_state_nxt = DONE;
      DONE:  if (r_out_valid && out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_mant      <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_float <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mant <= in_fixed;
            r_sign <= in_neg;
            r_exp  <= EXP_INIT;
            if (w_in_zero) r_out_float <= '0;
          end
        end
        NORM: begin
          if (!r_mant[FIX_W-1]) begin
            r_mant <= r_mant << 1;
            r_exp  <= r_exp - 8'd1;
          end
        end
        ROUND: begin
          r_out_float <= {r_sign, w_rnd_exp, w_rnd_frac};
          r_out_valid <= 1'b1;
        end
        DONE: begin
          // Zero skips ROUND, so valid is raised on the first DONE cycle.
          if (!r_out_valid)   r_out_valid <= 1'b1;
          else if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && reset_n;
  assign out_valid = r_out_valid;
  assign out_float = r_out_float;

endmodule

// File: tb/tb_fixed_to_float_packer.sv
module tb_fixed_to_float_packer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fixed;
  logic        in_neg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;

  fixed_to_float_packer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fixed  (in_fixed),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  bit   prev_v = 0;
  bit   expect_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: value = x * 2^-32. Normalise to [2^31,2^32), keep 24 bits,
  // round remainder to nearest, ties to even.
  function automatic void model(input logic [31:0] x, input bit neg,
                                output logic [31:0] f, output int lat);
    int          lz;
    logic [31:0] n;
    logic [24:0] sig;
    int          rem;
    int          e;
    if (x == 0) begin
      f = 32'h0;
      lat = 1;
      return;
    end
    lz = 0;
    n = x;
    while (n < 32'h8000_0000) begin
      n = n * 2;
      lz++;
    end
    sig = 25'(n / 256);
    rem = int'(n % 256);
    if (rem > 128 || (rem == 128 && sig % 2 == 1)) sig = sig + 1;
    e = 126 - lz;
    if (sig == 25'h100_0000) begin
      sig = sig / 2;
      e++;
    end
    f = {neg, 8'(e), sig[22:0]};
    lat = lz + 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+#1; accept happens on the next edge.
  task automatic send(input logic [31:0] x, input bit neg,
                      input logic [31:0] f, input int lat);
    exp_t e;
    int w = 0;
    while (!in_ready && w < 200) begin
      step();
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0, required 1");
      return;
    end
    in_valid = 1'b1;
    in_fixed = x;
    in_neg   = neg;
    e.f = f;
    e.lat = lat;
    e.t0 = cyc + 1;
    q.push_back(e);
    step();
    in_valid = 1'b0;
    in_fixed = $urandom;
    in_neg   = 1'($urandom);
  endtask

  task automatic send_m(input logic [31:0] x, input bit neg);
    logic [31:0] f;
    int lat;
    model(x, neg, f, lat);
    send(x, neg, f, lat);
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      step();
      w++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
      q.delete();
    end
  endtask

  // Compare process: drives out_ready, then checks outputs on every cycle.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom % 3 != 0);
      default: out_ready = 1'b0;
    endcase
    if (!reset_n) begin
      prev_v = 0;
      expect_rdy = 0;
    end else begin
      if (expect_rdy) chk("in_ready_after_hs", 32'(in_ready), 32'd1);
      expect_rdy = 0;
      if (out_valid) begin
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_valid: got out_valid=1 float=%h, required no output", out_float);
        end else begin
          if (!prev_v) chk("latency", 32'(cyc - q[0].t0), 32'(q[0].lat));
          chk("out_float", out_float, q[0].f);
          if (out_ready) begin
            void'(q.pop_front());
            expect_rdy = 1;
          end
        end
      end else if (prev_v) begin
        n_cmp++;
        n_fail++;
        $display("FAIL valid_dropped: got out_valid=0, required 1");
      end
      prev_v = out_valid && !out_ready;
    end
  end

  initial begin
    logic [31:0] f;
    int lat;
    logic [31:0] x;
    int t0;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_fixed = '0;
    in_neg   = 1'b0;
    out_ready = 1'b0;

    // Pin the model on hand-computed points.
    model(32'h8000_0000, 0, f, lat); chk("model_half", f, 32'h3F00_0000);
    model(32'hFFFF_FFFF, 0, f, lat); chk("model_carry", f, 32'h3F80_0000);
    model(32'h0000_0001, 1, f, lat); chk("model_min", f, 32'hAF80_0000);
    chk("model_min_lat", 32'(lat), 32'd33);
    model(32'h8000_0180, 0, f, lat); chk("model_tie_odd", f, 32'h3F00_0002);
    model(32'h8000_0080, 0, f, lat); chk("model_tie_even", f, 32'h3F00_0000);

    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_float", out_float, 32'h0);
    chk("rst_in_ready_gated", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);

    // Directed points with literal expectations.
    rdy_mode = 0;
    send(32'h8000_0000, 0, 32'h3F00_0000, 2);  drain();
    send(32'hFFFF_FFFF, 0, 32'h3F80_0000, 2);  drain();
    send(32'h0000_0001, 1, 32'hAF80_0000, 33); drain();
    send(32'h8000_0180, 0, 32'h3F00_0002, 2);  drain();
    send(32'h8000_0080, 0, 32'h3F00_0000, 2);  drain();
    send(32'h4000_0000, 0, 32'h3E80_0000, 3);  drain();

    // Negative zero becomes +0; output held while downstream stalls.
    rdy_mode = 2;
    send(32'h0, 1, 32'h0, 1);
    repeat (5) step();
    chk("hold_out_valid", 32'(out_valid), 32'd1);
    chk("hold_out_float", out_float, 32'h0);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    rdy_mode = 0;
    drain();

    // Reset in the middle of NORM aborts the conversion.
    send(32'h0000_0001, 0, 32'h2F80_0000, 33);
    t0 = cyc;
    repeat (9) step();
    reset_n = 1'b0;
    q.delete();
    step();
    chk("abort_cycle", 32'(cyc - t0), 32'd10);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_float", out_float, 32'h0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("abort_idle", 32'(in_ready), 32'd1);
    send(32'h8000_0000, 0, 32'h3F00_0000, 2);
    drain();

    // Randomised traffic with random downstream backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom % 5)
        0: x = $urandom;
        1: x = $urandom >> ($urandom % 32);
        2: x = (($urandom >> ($urandom % 24)) & 32'hFFFF_FF00) | 32'h80;
        3: x = ($urandom % 8 == 0) ? 32'h0 : (32'h1 << ($urandom % 32));
        default: x = 32'hFFFF_FFFF >> ($urandom % 32);
      endcase
      send_m(x, 1'($urandom));
      if ($urandom % 4 == 0) repeat ($urandom % 4) step();
    end
    drain();
    rdy_mode = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
